// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, DATA_W payload bits LSB first, optional parity, one stop bit.
// Parity support is compiled only when the macro UART_TX_PARITY_EN is defined.
module uart_tx_serializer #(
    parameter int PRESCALER = 16,
    parameter int DATA_W    = 8
) (
    input  logic              clk2,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    input  logic              parity_en,
    input  logic              par_type,
    output logic              tx_out,
    output logic              busy,
    output logic              tx_done
);

    localparam int BAUD_W = $clog2(PRESCALER);
    localparam int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(PRESCALER - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        , PARITY = 3'd4
`endif
    } state_t;

    state_t            state_r, state_s;
    logic [BAUD_W-1:0] baud_r, baud_s;
    logic [IDX_W-1:0]  idx_r, idx_s;
    logic [DATA_W-1:0] data_r, data_s;
    logic              tx_out_r, tx_out_s;
    logic              busy_r, busy_s;
    logic              tx_done_r, tx_done_s;
    logic              bit_end_s;

`ifdef UART_TX_PARITY_EN
    logic par_en_r, par_en_s;
    logic par_type_r, par_type_s;

    function automatic logic parity_of(input logic [DATA_W-1:0] d, input logic odd);
        parity_of = (^d) ^ odd;
    endfunction
`else
    logic unused_parity_s;
    assign unused_parity_s = parity_en ^ par_type;
`endif

    assign bit_end_s = (baud_r == BAUD_LAST);

    // Next-state, counters and the registered-output values derived from the next state
    always_comb begin
        state_s    = state_r;
        baud_s     = baud_r;
        idx_s      = idx_r;
        data_s     = data_r;
`ifdef UART_TX_PARITY_EN
        par_en_s   = par_en_r;
        par_type_s = par_type_r;
`endif
        case (state_r)
            IDLE: begin
                baud_s = {BAUD_W{1'b0}};
                idx_s  = {IDX_W{1'b0}};
                if (data_valid) begin
                    data_s     = data_in;
`ifdef UART_TX_PARITY_EN
                    par_en_s   = parity_en;
                    par_type_s = par_type;
`endif
                    state_s    = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (bit_end_s) begin
                    baud_s  = {BAUD_W{1'b0}};
                    state_s = DATA;
                end else begin
                    baud_s = baud_r + BAUD_W'(1);
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    baud_s = {BAUD_W{1'b0}};
                    if (idx_r == IDX_LAST) begin
                        idx_s = {IDX_W{1'b0}};
`ifdef UART_TX_PARITY_EN
                        state_s = par_en_r ? PARITY : STOP;
`else
                        state_s = STOP;
`endif
                    end else begin
                        idx_s = idx_r + IDX_W'(1);
                    end
                end else begin
                    baud_s = baud_r + BAUD_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end_s) begin
                    baud_s  = {BAUD_W{1'b0}};
                    state_s = STOP;
                end else begin
                    baud_s = baud_r + BAUD_W'(1);
                end
            end
`endif
            STOP: begin
                if (bit_end_s) begin
                    baud_s  = {BAUD_W{1'b0}};
                    state_s = IDLE;
                end else begin
                    baud_s = baud_r + BAUD_W'(1);
                end
            end
            default: begin
                state_s = IDLE;
                baud_s  = {BAUD_W{1'b0}};
                idx_s   = {IDX_W{1'b0}};
            end
        endcase

        // Outputs are registered from the next state so the line changes on the same edge as the FSM
        case (state_s)
            START:   tx_out_s = 1'b0;
            DATA:    tx_out_s = data_s[idx_s];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_out_s = parity_of(data_s, par_type_s);
`endif
            default: tx_out_s = 1'b1;
        endcase
        busy_s    = (state_s != IDLE);
        tx_done_s = (state_s == STOP) && (baud_s == BAUD_LAST);
    end

    // State, counters, latched frame and registered outputs
    always_ff @(posedge clk2) begin
        if (rst) begin
            state_r    <= IDLE;
            baud_r     <= {BAUD_W{1'b0}};
            idx_r      <= {IDX_W{1'b0}};
            data_r     <= {DATA_W{1'b0}};
            tx_out_r   <= 1'b1;
            busy_r     <= 1'b0;
            tx_done_r  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_r   <= 1'b0;
            par_type_r <= 1'b0;
`endif
        end else begin
            state_r    <= state_s;
            baud_r     <= baud_s;
            idx_r      <= idx_s;
            data_r     <= data_s;
            tx_out_r   <= tx_out_s;
            busy_r     <= busy_s;
            tx_done_r  <= tx_done_s;
`ifdef UART_TX_PARITY_EN
            par_en_r   <= par_en_s;
            par_type_r <= par_type_s;
`endif
        end
    end

    assign tx_out  = tx_out_r;
    assign busy    = busy_r;
    assign tx_done = tx_done_r;

endmodule
